multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle MIPS datapath: a Moore finite-state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It drives one shared memory port and one ALU. It supports R-format, lw, sw, beq, ori and j, and waits on a memory-ready handshake. It replaces the single-cycle opcode decoder and sits between the instruction register's opcode field and the datapath mux and write-enable controls.

## Interface
Parameters:
- OPW, 6, opcode width.
- EN_J, 1, enables the j instruction; when 0, j decodes as illegal.
- EN_ORI, 1, enables ori; when 0, ori decodes as illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  OPW  opcode from the instruction register; sampled in DECODE only.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdest, regwrite, alusrca, zeroext  out  1 each  datapath strobes and selects.
- alusrcb  out  2  ALU B-input select: 00 reg, 01 const 4, 10 immediate, 11 immediate<<2.
- aluop  out  2  ALU operation: 00 add, 01 sub, 10 funct, 11 or.
- pcsource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- illegal  out  1  one-cycle pulse when the opcode is unsupported.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- state  out  4  current state code, for debug.

## Operation
- Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, ori 0x0D, j 0x02.
- States and their outputs. Any signal not listed is 0.
- IDLE: all outputs 0. Goes to FETCH.
- FETCH: memread, alusrcb=01. irwrite, pcwrite and the exit to DECODE occur only when mem_ready=1; otherwise the FSM holds in FETCH.
- DECODE: alusrcb=11. Next state by opcode:
  - R to EXEC.
  - lw or sw to MEMADR.
  - beq to BRANCH.
  - ori to ORIEX.
  - j to JUMP.
  - Anything else: illegal=1, instr_done=1, then FETCH.
- MEMADR: alusrca, alusrcb=10. Goes to MEMRD for lw, MEMWR for sw. The opcode is latched in DECODE; op is not re-read here.
- MEMRD: memread, iord. Goes to MEMWB when mem_ready=1, otherwise holds.
- MEMWB: regwrite, memtoreg, instr_done. Goes to FETCH.
- MEMWR: memwrite, iord. When mem_ready=1: instr_done, then FETCH. Otherwise holds.
- EXEC: alusrca, aluop=10. Goes to RWB.
- RWB: regdest, regwrite, instr_done. Goes to FETCH.
- BRANCH: alusrca, aluop=01, pcwritecond, pcsource=01, instr_done. Goes to FETCH.
- ORIEX: alusrca, alusrcb=10, aluop=11, zeroext. Goes to ORIWB.
- ORIWB: regwrite, instr_done. regdest=0. Goes to FETCH.
- JUMP: pcwrite, pcsource=10, instr_done. Goes to FETCH.
- An instruction class is decoded once, in DECODE, and held in a 3-bit register until the next DECODE.

## Timing
- Reset: asynchronous entry to IDLE with all outputs 0 and the class register cleared. The first FETCH occurs on the first clk edge after rst_n rises.
- The state register updates on the rising edge. Outputs are combinational from state; in FETCH, MEMRD and MEMWR they also depend on mem_ready.
- With mem_ready held at 1, cycles per instruction: lw 5, sw 4, R 4, ori 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady while waiting.
- mem_ready is ignored in every other state.
- rst_n asserted mid-instruction aborts immediately. No write strobe may be high from reset assertion until the next FETCH.
- memread and memwrite are never high in the same cycle. regwrite is never high in FETCH, DECODE or MEMADR.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants;
  - the state enum (4-bit codes, IDLE=0);
  - the class enum;
  - the alusrcb, aluop and pcsource encodings.
- Sub-module mc_opdecode: a combinational map from opcode plus the EN_J/EN_ORI parameters to a class and an illegal flag. It is instantiated once and feeds the DECODE transition.
- Top level contains the state register, class register, next-state logic and output decode. Target size is about 200 lines.

## Test plan
- After reset with mem_ready=1, op=0x00: state sequence IDLE, FETCH, DECODE, EXEC, RWB. regdest=regwrite=1 and instr_done=1 in RWB, 4 cycles from the first FETCH.
- op=0x23 with mem_ready low for 2 cycles in MEMRD: 7-cycle lw. memread=iord=1 held across the wait; regwrite=memtoreg=1 exactly once.
- op=0x2B: memwrite=iord=1 for exactly one cycle once mem_ready=1, regwrite never asserted, 4 cycles total.
- op=0x04: BRANCH asserts pcwritecond=1, aluop=01, pcsource=01. op=0x02 with EN_J=1: pcwrite=1, pcsource=10 in JUMP.
- op=0x3F, and op=0x0D with EN_ORI=0: illegal pulses 1 cycle in DECODE, then FETCH, with no regwrite or memwrite.
- rst_n dropped during MEMWR: outputs 0 within the same cycle (asynchronous), state=IDLE, and no memwrite until the next sw.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes,
// FSM state codes, instruction classes and datapath select encodings.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_LW   = 3'd2,
        CL_SW   = 3'd3,
        CL_BEQ  = 3'd4,
        CL_ORI  = 3'd5,
        CL_J    = 3'd6,
        CL_ILL  = 3'd7
    } class_e;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_OR    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier: maps the instruction opcode to an instruction class,
// honouring the optional-instruction enables. Unsupported opcodes are
// reported as CL_ILL with the illegal flag set.
module mc_opdecode
    import ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter bit EN_J   = 1'b1,
    parameter bit EN_ORI = 1'b1
) (
    input  logic [OPW-1:0] op_i,
    output class_e         class_o,
    output logic           illegal_o
);

    // Priority-free opcode match; anything unmatched or disabled is illegal
    always_comb begin
        class_o   = CL_ILL;
        illegal_o = 1'b1;
        if (op_i == OPW'(OP_RTYPE)) begin
            class_o   = CL_R;
            illegal_o = 1'b0;
        end else if (op_i == OPW'(OP_LW)) begin
            class_o   = CL_LW;
            illegal_o = 1'b0;
        end else if (op_i == OPW'(OP_SW)) begin
            class_o   = CL_SW;
            illegal_o = 1'b0;
        end else if (op_i == OPW'(OP_BEQ)) begin
            class_o   = CL_BEQ;
            illegal_o = 1'b0;
        end else if (EN_ORI && (op_i == OPW'(OP_ORI))) begin
            class_o   = CL_ORI;
            illegal_o = 1'b0;
        end else if (EN_J && (op_i == OPW'(OP_J))) begin
            class_o   = CL_J;
            illegal_o = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences fetch,
// decode, execute, memory and write-back, stalling on mem_ready in the
// states that use the shared memory port.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter bit EN_J   = 1'b1,
    parameter bit EN_ORI = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           pcwritecond,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           irwrite,
    output logic           memtoreg,
    output logic           regdest,
    output logic           regwrite,
    output logic           alusrca,
    output logic           zeroext,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsource,
    output logic           illegal,
    output logic           instr_done,
    output logic [3:0]     state
);

    state_e state_q, state_d;
    class_e cls_q, cls_d;
    class_e decClass;
    logic   decIllegal;

    mc_opdecode #(
        .OPW    (OPW),
        .EN_J   (EN_J),
        .EN_ORI (EN_ORI)
    ) u_opdecode (
        .op_i      (op),
        .class_o   (decClass),
        .illegal_o (decIllegal)
    );

    assign state = state_q;

    // State and latched instruction class; reset aborts to IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= CL_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Next-state and Moore output decode (mem_ready gates the memory states)
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        zeroext     = 1'b0;
        alusrcb     = SRCB_REG;
        aluop       = ALU_ADD;
        pcsource    = PCSRC_ALU;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                cls_d   = decClass;
                case (decClass)
                    CL_R:         state_d = S_EXEC;
                    CL_LW, CL_SW: state_d = S_MEMADR;
                    CL_BEQ:       state_d = S_BRANCH;
                    CL_ORI:       state_d = S_ORIEX;
                    CL_J:         state_d = S_JUMP;
                    default: begin
                        illegal    = decIllegal;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (cls_q == CL_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                regdest    = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALU_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALU_OR;
                zeroext = 1'b1;
                state_d = S_ORIWB;
            end
            S_ORIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class
// state by state and compares the debug state plus every control output
// against hand-built expected bundles.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] op2;
    logic       mem_ready;

    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg;
    logic regdest, regwrite, alusrca, zeroext, illegal, instr_done;
    logic [1:0] alusrcb, aluop, pcsource;
    logic [3:0] state;

    logic pcwrite2, pcwritecond2, iord2, memread2, memwrite2, irwrite2, memtoreg2;
    logic regdest2, regwrite2, alusrca2, zeroext2, illegal2, instr_done2;
    logic [1:0] alusrcb2, aluop2, pcsource2;
    logic [3:0] state2;

    int errors = 0;
    int checks = 0;
    int rwCnt = 0;
    int mwCnt = 0;
    int rwStart, mwStart;

    // Output bundle layout: 13 strobes (MSB first) then alusrcb, aluop, pcsource
    localparam logic [18:0] B_PCW  = 19'd1 << 18;
    localparam logic [18:0] B_PCWC = 19'd1 << 17;
    localparam logic [18:0] B_IORD = 19'd1 << 16;
    localparam logic [18:0] B_MRD  = 19'd1 << 15;
    localparam logic [18:0] B_MWR  = 19'd1 << 14;
    localparam logic [18:0] B_IRW  = 19'd1 << 13;
    localparam logic [18:0] B_M2R  = 19'd1 << 12;
    localparam logic [18:0] B_RDST = 19'd1 << 11;
    localparam logic [18:0] B_RW   = 19'd1 << 10;
    localparam logic [18:0] B_ASA  = 19'd1 << 9;
    localparam logic [18:0] B_ZX   = 19'd1 << 8;
    localparam logic [18:0] B_ILL  = 19'd1 << 7;
    localparam logic [18:0] B_DONE = 19'd1 << 6;
    localparam logic [18:0] SB_4   = 19'd1 << 4;
    localparam logic [18:0] SB_IMM = 19'd2 << 4;
    localparam logic [18:0] SB_SH  = 19'd3 << 4;
    localparam logic [18:0] AO_SUB = 19'd1 << 2;
    localparam logic [18:0] AO_FN  = 19'd2 << 2;
    localparam logic [18:0] AO_OR  = 19'd3 << 2;
    localparam logic [18:0] PS_OUT = 19'd1;
    localparam logic [18:0] PS_J   = 19'd2;

    localparam logic [18:0] E_ZERO     = 19'd0;
    localparam logic [18:0] E_FETCH    = B_MRD | B_IRW | B_PCW | SB_4;
    localparam logic [18:0] E_FETCHW   = B_MRD | SB_4;
    localparam logic [18:0] E_DECODE   = SB_SH;
    localparam logic [18:0] E_ILL      = SB_SH | B_ILL | B_DONE;
    localparam logic [18:0] E_MEMADR   = B_ASA | SB_IMM;
    localparam logic [18:0] E_MEMRD    = B_MRD | B_IORD;
    localparam logic [18:0] E_MEMWB    = B_RW | B_M2R | B_DONE;
    localparam logic [18:0] E_MEMWR    = B_MWR | B_IORD | B_DONE;
    localparam logic [18:0] E_MEMWRW   = B_MWR | B_IORD;
    localparam logic [18:0] E_EXEC     = B_ASA | AO_FN;
    localparam logic [18:0] E_RWB      = B_RDST | B_RW | B_DONE;
    localparam logic [18:0] E_BRANCH   = B_ASA | AO_SUB | B_PCWC | PS_OUT | B_DONE;
    localparam logic [18:0] E_ORIEX    = B_ASA | SB_IMM | AO_OR | B_ZX;
    localparam logic [18:0] E_ORIWB    = B_RW | B_DONE;
    localparam logic [18:0] E_JUMP     = B_PCW | PS_J | B_DONE;

    wire [22:0] obs  = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                        memtoreg, regdest, regwrite, alusrca, zeroext, illegal, instr_done,
                        alusrcb, aluop, pcsource};
    wire [22:0] obs2 = {state2, pcwrite2, pcwritecond2, iord2, memread2, memwrite2, irwrite2,
                        memtoreg2, regdest2, regwrite2, alusrca2, zeroext2, illegal2, instr_done2,
                        alusrcb2, aluop2, pcsource2};

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdest(regdest),
        .regwrite(regwrite), .alusrca(alusrca), .zeroext(zeroext), .alusrcb(alusrcb),
        .aluop(aluop), .pcsource(pcsource), .illegal(illegal), .instr_done(instr_done),
        .state(state)
    );

    multicycle_control #(.EN_ORI(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op2), .mem_ready(mem_ready),
        .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2), .memread(memread2),
        .memwrite(memwrite2), .irwrite(irwrite2), .memtoreg(memtoreg2), .regdest(regdest2),
        .regwrite(regwrite2), .alusrca(alusrca2), .zeroext(zeroext2), .alusrcb(alusrcb2),
        .aluop(aluop2), .pcsource(pcsource2), .illegal(illegal2), .instr_done(instr_done2),
        .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally write strobes once per cycle, mid-cycle
    always @(negedge clk) begin
        if (regwrite) rwCnt++;
        if (memwrite) mwCnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op = OP_RTYPE; mem_ready = 1'b1;
        #3;
        checks++; if (obs !== {S_IDLE, E_ZERO}) begin errors++;
            $display("FAIL reset_async: got %h want %h", obs, {S_IDLE, E_ZERO}); end
        tick;
        checks++; if (obs !== {S_IDLE, E_ZERO}) begin errors++;
            $display("FAIL reset_held: got %h want %h", obs, {S_IDLE, E_ZERO}); end
        rst_n = 1'b1;
        #1;
        checks++; if (obs !== {S_IDLE, E_ZERO}) begin errors++;
            $display("FAIL reset_release_idle: got %h want %h", obs, {S_IDLE, E_ZERO}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL reset_first_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
    endtask

    task automatic test_rtype;
        op = OP_RTYPE;
        tick;
        checks++; if (obs !== {S_DECODE, E_DECODE}) begin errors++;
            $display("FAIL r_decode: got %h want %h", obs, {S_DECODE, E_DECODE}); end
        tick;
        checks++; if (obs !== {S_EXEC, E_EXEC}) begin errors++;
            $display("FAIL r_exec: got %h want %h", obs, {S_EXEC, E_EXEC}); end
        tick;
        checks++; if (obs !== {S_RWB, E_RWB}) begin errors++;
            $display("FAIL r_rwb: got %h want %h", obs, {S_RWB, E_RWB}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL r_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
    endtask

    task automatic test_lw;
        op = OP_LW; rwStart = rwCnt;
        tick;
        checks++; if (obs !== {S_DECODE, E_DECODE}) begin errors++;
            $display("FAIL lw_decode: got %h want %h", obs, {S_DECODE, E_DECODE}); end
        tick;
        checks++; if (obs !== {S_MEMADR, E_MEMADR}) begin errors++;
            $display("FAIL lw_memadr: got %h want %h", obs, {S_MEMADR, E_MEMADR}); end
        op = OP_RTYPE; mem_ready = 1'b0;
        tick;
        checks++; if (obs !== {S_MEMRD, E_MEMRD}) begin errors++;
            $display("FAIL lw_memrd_wait1: got %h want %h", obs, {S_MEMRD, E_MEMRD}); end
        tick;
        checks++; if (obs !== {S_MEMRD, E_MEMRD}) begin errors++;
            $display("FAIL lw_memrd_wait2: got %h want %h", obs, {S_MEMRD, E_MEMRD}); end
        tick;
        mem_ready = 1'b1;
        #1;
        checks++; if (obs !== {S_MEMRD, E_MEMRD}) begin errors++;
            $display("FAIL lw_memrd_ready: got %h want %h", obs, {S_MEMRD, E_MEMRD}); end
        tick;
        checks++; if (obs !== {S_MEMWB, E_MEMWB}) begin errors++;
            $display("FAIL lw_memwb: got %h want %h", obs, {S_MEMWB, E_MEMWB}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL lw_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
        checks++; if (rwCnt - rwStart !== 1) begin errors++;
            $display("FAIL lw_regwrite_count: got %0d want 1", rwCnt - rwStart); end
    endtask

    task automatic test_sw;
        op = OP_SW; rwStart = rwCnt; mwStart = mwCnt;
        tick;
        tick;
        checks++; if (obs !== {S_MEMADR, E_MEMADR}) begin errors++;
            $display("FAIL sw_memadr: got %h want %h", obs, {S_MEMADR, E_MEMADR}); end
        tick;
        checks++; if (obs !== {S_MEMWR, E_MEMWR}) begin errors++;
            $display("FAIL sw_memwr: got %h want %h", obs, {S_MEMWR, E_MEMWR}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL sw_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
        checks++; if ((mwCnt - mwStart !== 1) || (rwCnt - rwStart !== 0)) begin errors++;
            $display("FAIL sw_write_counts: got mw=%0d rw=%0d want mw=1 rw=0",
                     mwCnt - mwStart, rwCnt - rwStart); end
    endtask

    task automatic test_branch;
        op = OP_BEQ; mem_ready = 1'b0;
        #1;
        checks++; if (obs !== {S_FETCH, E_FETCHW}) begin errors++;
            $display("FAIL fetch_wait: got %h want %h", obs, {S_FETCH, E_FETCHW}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCHW}) begin errors++;
            $display("FAIL fetch_hold: got %h want %h", obs, {S_FETCH, E_FETCHW}); end
        mem_ready = 1'b1;
        tick;
        tick;
        checks++; if (obs !== {S_BRANCH, E_BRANCH}) begin errors++;
            $display("FAIL beq_branch: got %h want %h", obs, {S_BRANCH, E_BRANCH}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL beq_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
    endtask

    task automatic test_jump;
        op = OP_J;
        tick;
        tick;
        checks++; if (obs !== {S_JUMP, E_JUMP}) begin errors++;
            $display("FAIL j_jump: got %h want %h", obs, {S_JUMP, E_JUMP}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL j_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
    endtask

    task automatic test_illegal;
        op = 6'h3F; rwStart = rwCnt; mwStart = mwCnt;
        tick;
        checks++; if (obs !== {S_DECODE, E_ILL}) begin errors++;
            $display("FAIL ill_decode: got %h want %h", obs, {S_DECODE, E_ILL}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL ill_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
        checks++; if ((mwCnt - mwStart !== 0) || (rwCnt - rwStart !== 0)) begin errors++;
            $display("FAIL ill_write_counts: got mw=%0d rw=%0d want 0 0",
                     mwCnt - mwStart, rwCnt - rwStart); end
    endtask

    task automatic test_ori;
        op = OP_ORI; op2 = OP_ORI;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick;
        tick;
        checks++; if (obs !== {S_DECODE, E_DECODE}) begin errors++;
            $display("FAIL ori_decode_enabled: got %h want %h", obs, {S_DECODE, E_DECODE}); end
        checks++; if (obs2 !== {S_DECODE, E_ILL}) begin errors++;
            $display("FAIL ori_decode_disabled: got %h want %h", obs2, {S_DECODE, E_ILL}); end
        tick;
        checks++; if (obs !== {S_ORIEX, E_ORIEX}) begin errors++;
            $display("FAIL ori_oriex: got %h want %h", obs, {S_ORIEX, E_ORIEX}); end
        checks++; if (obs2 !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL ori_disabled_fetch: got %h want %h", obs2, {S_FETCH, E_FETCH}); end
        tick;
        checks++; if (obs !== {S_ORIWB, E_ORIWB}) begin errors++;
            $display("FAIL ori_oriwb: got %h want %h", obs, {S_ORIWB, E_ORIWB}); end
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL ori_back_to_fetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
    endtask

    task automatic test_reset_midwrite;
        op = OP_SW;
        tick;
        tick;
        mem_ready = 1'b0;
        tick;
        checks++; if (obs !== {S_MEMWR, E_MEMWRW}) begin errors++;
            $display("FAIL abort_memwr_wait: got %h want %h", obs, {S_MEMWR, E_MEMWRW}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (obs !== {S_IDLE, E_ZERO}) begin errors++;
            $display("FAIL abort_async: got %h want %h", obs, {S_IDLE, E_ZERO}); end
        tick;
        checks++; if (obs !== {S_IDLE, E_ZERO}) begin errors++;
            $display("FAIL abort_held: got %h want %h", obs, {S_IDLE, E_ZERO}); end
        mem_ready = 1'b1;
        rst_n = 1'b1;
        tick;
        checks++; if (obs !== {S_FETCH, E_FETCH}) begin errors++;
            $display("FAIL abort_refetch: got %h want %h", obs, {S_FETCH, E_FETCH}); end
        tick;
        tick;
        tick;
        checks++; if (obs !== {S_MEMWR, E_MEMWR}) begin errors++;
            $display("FAIL abort_next_sw: got %h want %h", obs, {S_MEMWR, E_MEMWR}); end
        tick;
    endtask

    // Hard time bound so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        op2 = OP_ORI;
        test_reset;
        test_rtype;
        test_lw;
        test_sw;
        test_branch;
        test_jump;
        test_illegal;
        test_ori;
        test_reset_midwrite;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
